// File: rtl/hd_cmd_parser.sv
// HD63484 host command parser: pops an opcode and its parameter words from the
// command FIFO and presents one complete command to the drawing engine.
// Optional starvation timeout in PARAM is enabled with `define HD_CMD_TIMEOUT_EN.
//
// Handshake: cmd_valid is held with every cmd_* output stable until the cycle
// cmd_ready=1 is seen at a clock edge; abort=1 overrides cmd_ready and any pop.
module hd_cmd_parser #(
    parameter int MAX_PARAMS = 3,
    parameter int TIMEOUT    = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fifo_empty,
    input  logic [15:0]               fifo_data,
    output logic                      fifo_rd,
    input  logic                      abort,
    output logic                      cmd_valid,
    input  logic                      cmd_ready,
    output logic [15:0]               cmd_word,
    output logic [5:0]                cmd_opcode,
    output logic [1:0]                cmd_nparams,
    output logic [16*MAX_PARAMS-1:0]  cmd_params,
    output logic                      cmd_unknown,
    output logic                      busy,
    output logic                      timeout_err,
    output logic [1:0]                dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PARAM = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [15:0]                  word_q;
    logic [1:0]                   n_q;
    logic                         unk_q;
    logic [1:0]                   cnt_q;
    logic [MAX_PARAMS-1:0][15:0]  params_q;

    logic       pop;
    logic       to_hit;
    logic [1:0] dec_n;
    logic       dec_unk;

    // Returns {unknown, parameter count} for an opcode.
    function automatic logic [2:0] decode(input logic [5:0] op);
        case (op)
            6'h01:                           decode = {1'b0, 2'd2};
            6'h02:                           decode = {1'b0, 2'd1};
            6'h16:                           decode = {1'b0, 2'd3};
            6'h20, 6'h21, 6'h22,
            6'h23, 6'h24, 6'h25:             decode = {1'b0, 2'd2};
            6'h29:                           decode = {1'b0, 2'd1};
            6'h2A:                           decode = {1'b0, 2'd3};
            6'h33:                           decode = {1'b0, 2'd0};
            default:                         decode = {1'b1, 2'd0};
        endcase
    endfunction

    assign {dec_unk, dec_n} = decode(fifo_data[15:10]);

    // Reset is folded in so that no word is consumed while the block is held in reset.
    assign pop = ((state == S_IDLE) || (state == S_PARAM)) &&
                 !fifo_empty && !abort && !rst;

`ifdef HD_CMD_TIMEOUT_EN
    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [TW-1:0] to_cnt;

    assign to_hit = (state == S_PARAM) && fifo_empty && !abort &&
                    (to_cnt == TW'(TIMEOUT));

    // Cleared whenever outside PARAM, so every entry to PARAM starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if ((state != S_PARAM) || pop || to_hit) begin
            to_cnt <= '0;
        end else if (fifo_empty) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (abort || to_hit) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        state_nxt = (dec_n == 2'd0) ? S_ISSUE : S_PARAM;
                    end
                end
                S_PARAM: begin
                    if (pop && (cnt_q == (n_q - 2'd1))) begin
                        state_nxt = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (cmd_ready) begin
                        state_nxt = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        fifo_rd     = 1'b0;
        cmd_valid   = 1'b0;
        busy        = 1'b0;
        timeout_err = 1'b0;
        fifo_rd     = pop;
        cmd_valid   = (state == S_ISSUE);
        busy        = (state != S_IDLE);
        timeout_err = to_hit;
    end

    // Command datapath: opcode pop starts a fresh command, parameter pops fill slots.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q   <= 16'h0000;
            n_q      <= 2'd0;
            unk_q    <= 1'b0;
            cnt_q    <= 2'd0;
            params_q <= '0;
        end else if (pop && (state == S_IDLE)) begin
            word_q   <= fifo_data;
            n_q      <= dec_n;
            unk_q    <= dec_unk;
            cnt_q    <= 2'd0;
            params_q <= '0;
        end else if (pop && (state == S_PARAM)) begin
            for (int k = 0; k < MAX_PARAMS; k++) begin
                if (int'(cnt_q) == k) begin
                    params_q[k] <= fifo_data;
                end
            end
            cnt_q <= cnt_q + 2'd1;
        end
    end

    assign cmd_word    = word_q;
    assign cmd_opcode  = word_q[15:10];
    assign cmd_nparams = n_q;
    assign cmd_unknown = unk_q;
    assign cmd_params  = params_q;
    assign dbg_state   = state;

endmodule

// File: tb/tb_hd_cmd_parser.sv
// Directed bench for hd_cmd_parser: table of complete commands plus hand-written
// stall, abort, reset and (with HD_CMD_TIMEOUT_EN) starvation sequences.
module tb_hd_cmd_parser;

    localparam int MP = 3;
`ifdef HD_CMD_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic              clk;
    logic              rst;
    logic              fifo_empty;
    logic [15:0]       fifo_data;
    logic              fifo_rd;
    logic              abort;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [15:0]       cmd_word;
    logic [5:0]        cmd_opcode;
    logic [1:0]        cmd_nparams;
    logic [16*MP-1:0]  cmd_params;
    logic              cmd_unknown;
    logic              busy;
    logic              timeout_err;
    logic [1:0]        dbg_state;

    logic [15:0] fifo_q[$];
    int          pops = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [15:0] w0, w1, w2, w3;
        int          nw;
        logic [5:0]  op;
        logic [1:0]  n;
        logic [47:0] prm;
        logic        unk;
    } vec_t;

    vec_t vecs[10];

    hd_cmd_parser #(.MAX_PARAMS(MP), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_empty  (fifo_empty),
        .fifo_data   (fifo_data),
        .fifo_rd     (fifo_rd),
        .abort       (abort),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_word    (cmd_word),
        .cmd_opcode  (cmd_opcode),
        .cmd_nparams (cmd_nparams),
        .cmd_params  (cmd_params),
        .cmd_unknown (cmd_unknown),
        .busy        (busy),
        .timeout_err (timeout_err),
        .dbg_state   (dbg_state)
    );

    // Clock / FIFO model: pops on the active edge, head word refreshed on the falling edge
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_rd) begin
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            pops = pops + 1;
        end
    end

    always @(negedge clk) begin
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = (fifo_q.size() == 0) ? 16'h0000 : fifo_q[0];
    end

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    // Push words just after a rising edge; they become visible at the next falling edge.
    task automatic push_words(input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic [15:0] d, input int nw);
        @(posedge clk);
        #1;
        if (nw > 0) fifo_q.push_back(a);
        if (nw > 1) fifo_q.push_back(b);
        if (nw > 2) fifo_q.push_back(c);
        if (nw > 3) fifo_q.push_back(d);
        cyc();
    endtask

    task automatic wait_valid(input int max_cyc, output int n_cyc);
        n_cyc = 0;
        for (int i = 1; i <= max_cyc; i++) begin
            cyc();
            if (cmd_valid) begin
                n_cyc = i;
                break;
            end
        end
        if (n_cyc == 0) chk("cmd_valid_seen", 48'(cmd_valid), 48'd1);
    endtask

    task automatic accept();
        cmd_ready = 1'b1;
        cyc();
        cmd_ready = 1'b0;
        chk("valid_after_accept", 48'(cmd_valid), 48'd0);
    endtask

    task automatic set_vec(input int i, input logic [15:0] w0, input logic [15:0] w1,
                           input logic [15:0] w2, input logic [15:0] w3, input int nw,
                           input logic [5:0] op, input logic [1:0] n,
                           input logic [47:0] prm, input logic unk);
        vecs[i].w0 = w0; vecs[i].w1 = w1; vecs[i].w2 = w2; vecs[i].w3 = w3;
        vecs[i].nw = nw; vecs[i].op = op; vecs[i].n = n;
        vecs[i].prm = prm; vecs[i].unk = unk;
    endtask

    task automatic run_vec(input int i);
        int p0;
        int lat;
        p0 = pops;
        push_words(vecs[i].w0, vecs[i].w1, vecs[i].w2, vecs[i].w3, vecs[i].nw);
        wait_valid(10, lat);
        chk($sformatf("v%0d_latency", i), 48'(lat), 48'(int'(vecs[i].n) + 1));
        chk($sformatf("v%0d_word", i), 48'(cmd_word), 48'(vecs[i].w0));
        chk($sformatf("v%0d_opcode", i), 48'(cmd_opcode), 48'(vecs[i].op));
        chk($sformatf("v%0d_nparams", i), 48'(cmd_nparams), 48'(vecs[i].n));
        chk($sformatf("v%0d_params", i), cmd_params, vecs[i].prm);
        chk($sformatf("v%0d_unknown", i), 48'(cmd_unknown), 48'(vecs[i].unk));
        chk($sformatf("v%0d_pops", i), 48'(pops - p0), 48'(vecs[i].nw));
        accept();
        chk($sformatf("v%0d_busy_after", i), 48'(busy), 48'd0);
    endtask

    initial begin
        int p0;
        int lat;
        rst        = 1'b1;
        abort      = 1'b0;
        cmd_ready  = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = 16'h0000;

        set_vec(0, 16'h8800, 16'h0010, 16'h0020, 16'h0, 3, 6'h22, 2'd2, {16'h0, 16'h0020, 16'h0010}, 1'b0);
        set_vec(1, 16'h0400, 16'hAAAA, 16'h5555, 16'h0, 3, 6'h01, 2'd2, {16'h0, 16'h5555, 16'hAAAA}, 1'b0);
        set_vec(2, 16'h0801, 16'h1234, 16'h0,    16'h0, 2, 6'h02, 2'd1, {32'h0, 16'h1234}, 1'b0);
        set_vec(3, 16'h5800, 16'h0001, 16'h0002, 16'h0003, 4, 6'h16, 2'd3, {16'h0003, 16'h0002, 16'h0001}, 1'b0);
        set_vec(4, 16'hCC00, 16'h0,    16'h0,    16'h0, 1, 6'h33, 2'd0, 48'h0, 1'b0);
        set_vec(5, 16'hFC00, 16'h0,    16'h0,    16'h0, 1, 6'h3F, 2'd0, 48'h0, 1'b1);
        set_vec(6, 16'hA800, 16'h0007, 16'h0008, 16'h0009, 4, 6'h2A, 2'd3, {16'h0009, 16'h0008, 16'h0007}, 1'b0);
        set_vec(7, 16'h0000, 16'h0,    16'h0,    16'h0, 1, 6'h00, 2'd0, 48'h0, 1'b1);
        set_vec(8, 16'h9400, 16'h1111, 16'h2222, 16'h0, 3, 6'h25, 2'd2, {16'h0, 16'h2222, 16'h1111}, 1'b0);
        set_vec(9, 16'hA400, 16'h0005, 16'h0,    16'h0, 2, 6'h29, 2'd1, {32'h0, 16'h0005}, 1'b0);

        // Reset state
        repeat (2) cyc();
        chk("rst_valid", 48'(cmd_valid), 48'd0);
        chk("rst_word", 48'(cmd_word), 48'd0);
        chk("rst_nparams", 48'(cmd_nparams), 48'd0);
        chk("rst_params", cmd_params, 48'd0);
        chk("rst_unknown", 48'(cmd_unknown), 48'd0);
        chk("rst_busy", 48'(busy), 48'd0);
        chk("rst_timeout", 48'(timeout_err), 48'd0);
        chk("rst_state", 48'(dbg_state), 48'd0);
        rst = 1'b0;
        cyc();
        chk("idle_empty_rd", 48'(fifo_rd), 48'd0);

        for (int i = 0; i < 10; i++) run_vec(i);

        // DOT stalled by cmd_ready=0, WPR queued behind it
        p0 = pops;
        push_words(16'hCC00, 16'h0801, 16'h1234, 16'h0, 3);
        wait_valid(10, lat);
        chk("dot_latency", 48'(lat), 48'd1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("dot_stall_valid", 48'(cmd_valid), 48'd1);
            chk("dot_stall_word", 48'(cmd_word), 48'hCC00);
            chk("dot_stall_nparams", 48'(cmd_nparams), 48'd0);
            chk("dot_stall_rd", 48'(fifo_rd), 48'd0);
            chk("dot_stall_pops", 48'(pops - p0), 48'd1);
        end
        accept();
        wait_valid(10, lat);
        chk("wpr_latency", 48'(lat), 48'd2);
        chk("wpr_word", 48'(cmd_word), 48'h0801);
        chk("wpr_params", cmd_params, {32'h0, 16'h1234});
        chk("wpr_pops", 48'(pops - p0), 48'd3);
        accept();

        // Abort in PARAM with one of three CLR params collected
        p0 = pops;
        push_words(16'h5800, 16'h0001, 16'h0, 16'h0, 2);
        cyc();
        cyc();
        chk("abort_pre_busy", 48'(busy), 48'd1);
        chk("abort_pre_pops", 48'(pops - p0), 48'd2);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_busy", 48'(busy), 48'd0);
        chk("abort_valid", 48'(cmd_valid), 48'd0);
        repeat (3) begin
            cyc();
            chk("abort_no_valid", 48'(cmd_valid), 48'd0);
        end
        // Abort also blocks an opcode pop in IDLE and leaves the word in the FIFO
        push_words(16'hCC00, 16'h0, 16'h0, 16'h0, 1);
        abort = 1'b1;
        #1;
        chk("abort_blocks_rd", 48'(fifo_rd), 48'd0);
        cyc();
        abort = 1'b0;
        #1;
        chk("abort_word_kept", 48'(fifo_q.size()), 48'd1);
        chk("post_abort_rd", 48'(fifo_rd), 48'd1);
        wait_valid(10, lat);
        chk("post_abort_dot", 48'(cmd_opcode), 48'h33);
        accept();
        push_words(16'hA400, 16'h0005, 16'h0, 16'h0, 2);
        wait_valid(10, lat);
        chk("crcl_latency", 48'(lat), 48'd2);
        chk("crcl_opcode", 48'(cmd_opcode), 48'h29);
        chk("crcl_params", cmd_params, {32'h0, 16'h0005});
        accept();

        // Reset mid-PARAM
        push_words(16'h5800, 16'h0001, 16'h0, 16'h0, 2);
        cyc();
        cyc();
        chk("rstmid_pre_busy", 48'(busy), 48'd1);
        rst = 1'b1;
        #1;
        chk("rstmid_busy", 48'(busy), 48'd0);
        chk("rstmid_valid", 48'(cmd_valid), 48'd0);
        chk("rstmid_word", 48'(cmd_word), 48'd0);
        chk("rstmid_params", cmd_params, 48'd0);
        chk("rstmid_nparams", 48'(cmd_nparams), 48'd0);
        chk("rstmid_rd", 48'(fifo_rd), 48'd0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("rstrel_rd", 48'(fifo_rd), 48'd0);
        chk("rstrel_busy", 48'(busy), 48'd0);
        chk("rstrel_valid", 48'(cmd_valid), 48'd0);

`ifdef HD_CMD_TIMEOUT_EN
        // Starvation: ELPS opcode with no params behind it
        push_words(16'hA800, 16'h0, 16'h0, 16'h0, 1);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            chk("to_no_valid", 48'(cmd_valid), 48'd0);
            if (timeout_err) begin
                lat = i;
                break;
            end
        end
        chk("to_cycle", 48'(lat), 48'd9);
        cyc();
        chk("to_pulse_end", 48'(timeout_err), 48'd0);
        chk("to_idle", 48'(busy), 48'd0);
        chk("to_valid", 48'(cmd_valid), 48'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
